// File: rtl/fifo_sram_ctrl.sv
// rtl/fifo_sram_ctrl.sv - circular-buffer FIFO controller for a registered-read SRAM macro
module fifo_sram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 8,
    parameter int AFULL_TH   = 2**BUS_WIDTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [BUS_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  sram_cs,
    output logic                  sram_rd_en,
    output logic                  sram_wr_en,
    output logic [BUS_WIDTH-1:0]  sram_read_addr,
    output logic [BUS_WIDTH-1:0]  sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    localparam int DEPTH = 2**BUS_WIDTH;

    logic [BUS_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [BUS_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [BUS_WIDTH:0] count_q, count_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               accept_en, push_ok, pop_ok;

    assign full         = (count_q == (BUS_WIDTH+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AFULL_TH);
    assign almost_empty = (int'(count_q) <= AEMPTY_TH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Reset and flush both swallow requests, so no strobe or error can escape them.
    assign accept_en = !rst && !flush;
    assign pop_ok    = accept_en && pop && !empty;
    assign push_ok   = accept_en && push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            rd_valid_d  = pop_ok;
            overflow_d  = push && !push_ok;
            underflow_d = pop && !pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        rd_valid_q  <= rd_valid_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    // Read enable stays high through the data-return cycle so the macro keeps Dout driven.
    assign rd_valid        = rd_valid_q && !rst;
    assign sram_rd_en      = (pop_ok || rd_valid_q) && !rst;
    assign sram_wr_en      = push_ok;
    assign sram_cs         = sram_rd_en || sram_wr_en;
    assign sram_read_addr  = rd_ptr_q[BUS_WIDTH-1:0];
    assign sram_write_addr = wr_ptr_q[BUS_WIDTH-1:0];
    assign sram_din        = wr_data;
    assign rd_data         = rd_valid ? sram_dout : '0;
endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// tb/tb_fifo_sram_ctrl.sv - directed self-checking bench for fifo_sram_ctrl at depth 4
module tb_fifo_sram_ctrl;
    localparam int DW = 8;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst, push, pop, flush;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data, sram_din;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [BW:0]   count;
    logic          overflow, underflow, sram_cs, sram_rd_en, sram_wr_en;
    logic [BW-1:0] sram_read_addr, sram_write_addr;
    wire  [DW-1:0] sram_dout;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] mem_q;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_words [4];

    always #5 clk = ~clk;

    // Registered-read SRAM: a same-edge read sees the old word before the write lands.
    always @(posedge clk) begin
        if (sram_rd_en) mem_q <= mem[sram_read_addr];
        if (sram_wr_en) mem[sram_write_addr] <= sram_din;
    end
    assign sram_dout = sram_rd_en ? mem_q : 8'hzz;

    fifo_sram_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .AFULL_TH(2), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop), .flush(flush),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .sram_cs(sram_cs),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_read_addr(sram_read_addr), .sram_write_addr(sram_write_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; wr_data = '0;
        #1;
        push = 1'b1; pop = 1'b1; #1;
        chk("rst_wr_en", 32'(sram_wr_en), 0);
        chk("rst_cs", 32'(sram_cs), 0);
        tick(); tick();
        push = 1'b0; pop = 1'b0; rst = 1'b0; #1;
        chk("reset_empty", 32'(empty), 1);
        chk("reset_count", 32'(count), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_aempty", 32'(almost_empty), 1);
        chk("reset_afull", 32'(almost_full), 0);
        chk("reset_strobes", 32'({sram_cs, sram_rd_en, sram_wr_en}), 0);
        chk("reset_err", 32'({overflow, underflow}), 0);

        exp_words[0] = 8'hA1; exp_words[1] = 8'hB2; exp_words[2] = 8'hC3; exp_words[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; wr_data = exp_words[i]; #1;
            chk("fill_wr_en", 32'(sram_wr_en), 1);
            chk("fill_waddr", 32'(sram_write_addr), 32'(i));
            chk("fill_din", 32'(sram_din), 32'(exp_words[i]));
            tick();
        end
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 4);
        chk("full_afull", 32'(almost_full), 1);
        wr_data = 8'h99; #1;
        chk("ovf_no_wr", 32'(sram_wr_en), 0);
        tick();
        push = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        tick();
        chk("ovf_clear", 32'(overflow), 0);

        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pop_rd_en", 32'(sram_rd_en), 1);
            chk("pop_raddr", 32'(sram_read_addr), 32'(i));
            tick();
            chk("pop_valid", 32'(rd_valid), 1);
            chk("pop_data", 32'(rd_data), 32'(exp_words[i]));
        end
        chk("drain_empty", 32'(empty), 1);
        tick();
        pop = 1'b0;
        chk("unf_pulse", 32'(underflow), 1);
        chk("unf_no_valid", 32'(rd_valid), 0);
        chk("unf_rd_data_zero", 32'(rd_data), 0);
        tick();
        chk("unf_clear", 32'(underflow), 0);

        for (int i = 0; i < 4; i++) begin
            push = 1'b1; wr_data = exp_words[i]; tick();
        end
        chk("refill_count", 32'(count), 4);
        wr_data = 8'hEE; pop = 1'b1; #1;
        chk("fullpp_wr_en", 32'(sram_wr_en), 1);
        chk("fullpp_waddr", 32'(sram_write_addr), 0);
        chk("fullpp_raddr", 32'(sram_read_addr), 0);
        tick();
        push = 1'b0;
        chk("fullpp_data", 32'(rd_data), 32'hA1);
        chk("fullpp_count", 32'(count), 4);
        exp_words[0] = 8'hB2; exp_words[1] = 8'hC3; exp_words[2] = 8'hD4; exp_words[3] = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) pop = 1'b0;
            chk("wrap_valid", 32'(rd_valid), 1);
            chk("wrap_data", 32'(rd_data), 32'(exp_words[i]));
        end
        chk("wrap_empty", 32'(empty), 1);

        tick();
        push = 1'b1; pop = 1'b1; wr_data = 8'h55; #1;
        chk("epp_wr_en", 32'(sram_wr_en), 1);
        tick();
        push = 1'b0;
        chk("epp_unf", 32'(underflow), 1);
        chk("epp_count", 32'(count), 1);
        chk("epp_no_valid", 32'(rd_valid), 0);
        tick();
        pop = 1'b0;
        chk("epp_data", 32'(rd_data), 32'h55);
        chk("epp_valid", 32'(rd_valid), 1);

        exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; wr_data = exp_words[i]; tick();
        end
        push = 1'b0;
        chk("pre_flush_count", 32'(count), 3);
        pop = 1'b1; tick();
        pop = 1'b0; flush = 1'b1; push = 1'b1; wr_data = 8'h77; #1;
        chk("flush_inflight_valid", 32'(rd_valid), 1);
        chk("flush_inflight_data", 32'(rd_data), 32'h11);
        chk("flush_no_wr", 32'(sram_wr_en), 0);
        tick();
        flush = 1'b0; push = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_no_ovf", 32'(overflow), 0);
        chk("flush_no_valid", 32'(rd_valid), 0);

        push = 1'b1; wr_data = 8'h61; tick();
        wr_data = 8'h62; tick();
        push = 1'b0; pop = 1'b1; tick();
        pop = 1'b0; rst = 1'b1; #1;
        chk("midrst_valid", 32'(rd_valid), 0);
        chk("midrst_cs", 32'(sram_cs), 0);
        tick();
        rst = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_no_stale", 32'(rd_valid), 0);
        push = 1'b1; wr_data = 8'h9C; #1;
        chk("postrst_waddr", 32'(sram_write_addr), 0);
        tick();
        push = 1'b0; pop = 1'b1; tick();
        pop = 1'b0;
        chk("postrst_data", 32'(rd_data), 32'h9C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_sram_ctrl.md
Name: fifo_sram_ctrl

Overview:
- Synchronous FIFO controller that sequences one single-port-read/single-port-write SRAM macro (registered read, tri-stated Dout while unselected) as a circular buffer of depth 2**BUS_WIDTH.
- Owns the read/write pointers, occupancy count, status flags and SRAM strobes.
- Presents a push/pop interface to the producer and consumer, with a one-cycle read-data-valid return.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word and of the SRAM data ports.
- BUS_WIDTH, 8, SRAM address width; depth DEPTH = 2**BUS_WIDTH.
- AFULL_TH, 2**BUS_WIDTH-2, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request, wr_data sampled same cycle.
- wr_data  in  DATA_WIDTH  word to enqueue.
- pop  in  1  read request.
- flush  in  1  synchronous empty of FIFO, memory contents untouched.
- rd_data  out  DATA_WIDTH  dequeued word, valid only when rd_valid=1.
- rd_valid  out  1  rd_data qualifier, one cycle after an accepted pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  BUS_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: push refused.
- underflow  out  1  one-cycle pulse: pop refused.
- sram_cs  out  1  SRAM chip select.
- sram_rd_en  out  1  SRAM read strobe.
- sram_wr_en  out  1  SRAM write strobe.
- sram_read_addr  out  BUS_WIDTH  SRAM read address.
- sram_write_addr  out  BUS_WIDTH  SRAM write address.
- sram_din  out  DATA_WIDTH  SRAM write data.
- sram_dout  in  DATA_WIDTH  SRAM read data, tri-stated when not read-enabled.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr, rd_ptr, count and rd_valid clear to 0.
  - overflow and underflow clear to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (for AFULL_TH>0).
  - All SRAM strobes are 0 while rst=1.
  - Reset overrides push, pop and flush, and aborts any pending rd_valid; no rd_valid in the cycle after reset.
- Pointers:
  - BUS_WIDTH+1 bits each; low BUS_WIDTH bits drive the SRAM addresses.
  - The MSB is a wrap bit; pointers wrap naturally modulo 2*DEPTH.
- Flags are combinational from the registered count; count is registered.
- Acceptance rules:
  - push_ok = push & (!full | pop_ok).
  - pop_ok = pop & !empty.
  - Push to a full FIFO with a simultaneous valid pop is accepted. The write lands at the address just vacated, and the read returns the old word (SRAM read-before-write).
  - Push and pop on an empty FIFO: only the push is accepted; underflow pulses.
- Cycle N, push_ok: sram_wr_en=1, sram_write_addr=wr_ptr[BUS_WIDTH-1:0], sram_din=wr_data. wr_ptr increments at the end of cycle N.
- Cycle N, pop_ok: sram_rd_en=1, sram_read_addr=rd_ptr[BUS_WIDTH-1:0]. rd_ptr increments at the end of cycle N.
  - Cycle N+1: rd_valid=1, sram_rd_en held at 1 so Dout is driven, rd_data=sram_dout. Pop latency is 1 cycle.
  - Back-to-back pops stream one word per cycle.
- sram_read_addr always presents the current rd_ptr. A hold-cycle read re-fetches that address, which is harmless.
- sram_cs = sram_rd_en | sram_wr_en.
- rd_data is 0 when rd_valid=0; never pass Z through.
- count update per cycle: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Error pulses:
  - overflow = registered (push & !push_ok).
  - underflow = registered (pop & !pop_ok).
  - Each is a one-cycle pulse the cycle after the refused request.
- flush:
  - At posedge, rd_ptr <= wr_ptr and count <= 0; push and pop in the same cycle are ignored (no error pulses).
  - An rd_valid already pending from the previous cycle still completes.
- The controller never issues an SRAM write while rst=1. Initialisation of SRAM contents is not this block's job.

Test Plan:
- BUS_WIDTH=2 (depth 4), reset -> empty=1, count=0, rd_valid=0, all sram strobes 0.
- Push 0xA1,0xB2,0xC3,0xD4 on consecutive cycles -> full=1 and count=4 after the 4th; a 5th push -> no sram_wr_en, overflow pulses one cycle later, count stays 4.
- Pop x4 back-to-back -> rd_valid high 4 consecutive cycles with rd_data A1,B2,C3,D4; empty=1 after; a 5th pop -> underflow pulse, no rd_valid.
- Fill to 4, then simultaneous push 0xEE + pop -> rd_data=A1, count stays 4; drain -> B2,C3,D4,EE. Pointers wrap past address 3 correctly.
- Empty FIFO, simultaneous push 0x55 + pop -> push accepted, underflow pulses, count=1; next pop returns 0x55.
- Count=3 with a pop in flight, assert flush and push together -> in-flight rd_valid completes, count=0, empty=1, push ignored; subsequently assert rst mid-stream -> all state cleared, no stale rd_valid.
